seg7_scan_capture: RTL

- Receive-side counterpart of the team's hex-to-7-segment digit encoder.
- Observes a time-multiplexed common-anode 7-segment display bus (active-low anode selects, active-low segments) and reconstructs the displayed hex value.
- Used as an on-chip display monitor for self-check and loopback tests of the display path.
- Output is a frame: one decoded nibble per digit plus a per-digit pattern-error mask.

---
 rtl/seg7_pkg.sv | 71 +++++++
 rtl/seg7_pattern_decode.sv | 14 +
 rtl/seg7_scan_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern table (active-low, bit6=g .. bit0=a) used by the encoder and the capture monitor.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HOLD
    } scan_state_t;

    // Returns {valid, nibble}; unknown patterns yield {0, 4'h0}.
    function automatic logic [4:0] seg7_to_nibble(input logic [6:0] seg);
        case (seg)
            SEG_0:   return {1'b1, 4'h0};
            SEG_1:   return {1'b1, 4'h1};
            SEG_2:   return {1'b1, 4'h2};
            SEG_3:   return {1'b1, 4'h3};
            SEG_4:   return {1'b1, 4'h4};
            SEG_5:   return {1'b1, 4'h5};
            SEG_6:   return {1'b1, 4'h6};
            SEG_7:   return {1'b1, 4'h7};
            SEG_8:   return {1'b1, 4'h8};
            SEG_9:   return {1'b1, 4'h9};
            SEG_A:   return {1'b1, 4'hA};
            SEG_B:   return {1'b1, 4'hB};
            SEG_C:   return {1'b1, 4'hC};
            SEG_D:   return {1'b1, 4'hD};
            SEG_E:   return {1'b1, 4'hE};
            SEG_F:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    function automatic logic [6:0] nibble_to_seg7(input logic [3:0] nib);
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to {valid, nibble} decoder.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       valid_o
);

    always_comb begin
        {valid_o, nibble_o} = seg7_to_nibble(seg_i);
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Display bus monitor: samples each multiplexed digit once it has been stable long enough
// and publishes a complete frame of nibbles plus per-digit pattern-error flags.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int SETTLE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [6:0]            seg_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  frame_valid
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW   = $clog2(SETTLE + 1);
    localparam int BUSW = DIGITS + 7;

    logic [DIGITS-1:0]   an_meta_q, an_s_q;
    logic [6:0]          seg_meta_q, seg_s_q;
    logic [BUSW-1:0]     bus_s, bus_prev_q;
    logic                bus_same;
    logic [CW-1:0]       cnt_q, cnt_d;
    scan_state_t         state_q, state_d;
    logic                capture;
    logic [3:0]          low_cnt;
    logic [IDXW-1:0]     dig_idx;
    logic                one_low;
    logic [3:0]          dec_nib;
    logic                dec_valid;
    logic [DIGITS-1:0]   seen_q, seen_d, cap_hit;
    logic                frame_done;
    logic [4*DIGITS-1:0] shadow_nib, value_q;
    logic [DIGITS-1:0]   shadow_err, err_q;
    logic                fv_q;

    assign bus_s      = {an_s_q, seg_s_q};
    assign bus_same   = (bus_s == bus_prev_q);
    assign one_low    = (low_cnt == 4'd1);
    assign frame_done = &seen_q;

    seg7_pattern_decode u_decode (
        .seg_i    (seg_s_q),
        .nibble_o (dec_nib),
        .valid_o  (dec_valid)
    );

    // Count low anodes; dig_idx is only meaningful when exactly one is low.
    always_comb begin
        low_cnt = '0;
        dig_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s_q[i]) begin
                low_cnt = low_cnt + 4'd1;
                dig_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!bus_same) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(SETTLE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (one_low) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!bus_same)                     state_d = one_low ? ST_SETTLE : ST_WAIT;
                else if (cnt_q >= CW'(SETTLE - 1)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus_same) state_d = one_low ? ST_SETTLE : ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        capture = (state_q == ST_SETTLE) && bus_same && (cnt_q >= CW'(SETTLE - 1));
    end

    // Per-digit shadow slots; a re-capture before frame completion simply overwrites.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
        logic [3:0] nib_q;
        logic       bad_q;

        assign cap_hit[gi] = capture && (dig_idx == IDXW'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                nib_q <= '0;
                bad_q <= 1'b0;
            end else if (cap_hit[gi]) begin
                nib_q <= dec_nib;
                bad_q <= ~dec_valid;
            end
        end

        assign shadow_nib[4*gi +: 4] = nib_q;
        assign shadow_err[gi]        = bad_q;
    end

    // A capture landing on the publish edge starts the next frame.
    assign seen_d = (frame_done ? '0 : seen_q) | cap_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_q  <= '1;
            an_s_q     <= '1;
            seg_meta_q <= '1;
            seg_s_q    <= '1;
            bus_prev_q <= '1;
            cnt_q      <= '0;
            seen_q     <= '0;
            value_q    <= '0;
            err_q      <= '0;
            fv_q       <= 1'b0;
        end else begin
            an_meta_q  <= an_n;
            an_s_q     <= an_meta_q;
            seg_meta_q <= seg_n;
            seg_s_q    <= seg_meta_q;
            bus_prev_q <= bus_s;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            fv_q       <= frame_done;
            if (frame_done) begin
                value_q <= shadow_nib;
                err_q   <= shadow_err;
            end
        end
    end

    assign value       = value_q;
    assign err_mask    = err_q;
    assign frame_valid = fv_q;

endmodule
